// File: rtl/polylut_result_collector.sv
// Credit-controlled admission and result capture for the free-running polylut pipeline:
// tracks sample validity through the fixed latency, reduces scores to argmax, buffers in a FWFT FIFO.
module polylut_result_collector #(
    parameter int IN_WIDTH     = 48,
    parameter int NUM_CLASSES  = 5,
    parameter int SCORE_WIDTH  = 3,
    parameter int PIPE_LATENCY = 6,
    parameter int FIFO_DEPTH   = 8,
    parameter bit SCORE_SIGNED = 1'b1,
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_WIDTH-1:0]                in_data,
    output logic [IN_WIDTH-1:0]                pipe_in,
    input  logic [NUM_CLASSES*SCORE_WIDTH-1:0] pipe_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CLS_W-1:0]                   out_class,
    output logic [SCORE_WIDTH-1:0]             out_score,
    output logic                               busy,
    output logic                               err_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = CLS_W + SCORE_WIDTH;

    logic [CNT_W-1:0]        credits;
    logic [PIPE_LATENCY-1:0] valid_sr;
    logic                    fire;
    logic                    pop;
    logic                    pipe_valid;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_wr;
    logic [ENT_W-1:0]        mem [FIFO_DEPTH];
    logic [ENT_W-1:0]        head_ent;
    logic [CLS_W-1:0]        win_cls;
    logic [SCORE_WIDTH-1:0]  win_score;

    function automatic logic score_gt(input logic [SCORE_WIDTH-1:0] a,
                                      input logic [SCORE_WIDTH-1:0] b);
        logic signed [SCORE_WIDTH-1:0] sa;
        logic signed [SCORE_WIDTH-1:0] sb;
        sa = a;
        sb = b;
        if (SCORE_SIGNED)
            return sa > sb;
        else
            return a > b;
    endfunction

    assign pipe_in    = in_data;
    assign in_ready   = (credits != '0) & ~rst;
    assign fire       = in_valid & in_ready;
    assign pipe_valid = valid_sr[PIPE_LATENCY-1];

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    // A same-cycle pop frees the slot, so a write into a full FIFO is still accepted then.
    assign fifo_wr    = pipe_valid & (~fifo_full | pop);

    assign busy = (|valid_sr) | ~fifo_empty;

    // Admission credits: one per FIFO slot, returned only when a result leaves.
    always_ff @(posedge clk) begin
        if (rst)
            credits <= CNT_W'(FIFO_DEPTH);
        else if (fire & ~pop)
            credits <= credits - CNT_W'(1);
        else if (pop & ~fire)
            credits <= credits + CNT_W'(1);
    end

    // Validity shadow of the pipeline stages
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= fire;
            for (int i = 1; i < PIPE_LATENCY; i++)
                valid_sr[i] <= valid_sr[i-1];
        end
    end

    // Argmax over the pipeline output; strict compare keeps the lowest index on ties.
    always_comb begin
        win_cls   = '0;
        win_score = pipe_out[0 +: SCORE_WIDTH];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (score_gt(pipe_out[k*SCORE_WIDTH +: SCORE_WIDTH], win_score)) begin
                win_cls   = CLS_W'(k);
                win_score = pipe_out[k*SCORE_WIDTH +: SCORE_WIDTH];
            end
        end
    end

    // Result FIFO control
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (fifo_wr & ~pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop & ~fifo_wr)
                fifo_count <= fifo_count - CNT_W'(1);
            if (pipe_valid & fifo_full & ~pop)
                err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= {win_cls, win_score};
    end

    assign head_ent  = mem[rd_ptr];
    assign out_class = out_valid ? head_ent[ENT_W-1 -: CLS_W] : '0;
    assign out_score = out_valid ? head_ent[SCORE_WIDTH-1:0] : '0;

endmodule
